// File: rtl/piccolo128_dec_iter.sv
// Iterative Piccolo-128 decryption core: one of 31 rounds per clock.
// Round keys are picked from the stored master key by round index.
module piccolo128_dec_iter (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [0:127] keyin,
    input  logic [0:63]  ciphertext,
    output logic [0:63]  plaintext,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e       fsm_q;
    logic [4:0]   round_q;
    logic [0:127] key_q;
    logic [0:63]  state_q;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'he;  4'h1: return 4'h4;  4'h2: return 4'hb;  4'h3: return 4'h2;
            4'h4: return 4'h3;  4'h5: return 4'h8;  4'h6: return 4'h0;  4'h7: return 4'h9;
            4'h8: return 4'h1;  4'h9: return 4'ha;  4'ha: return 4'h7;  4'hb: return 4'hf;
            4'hc: return 4'h6;  4'hd: return 4'hc;  4'he: return 4'h5;  default: return 4'hd;
        endcase
    endfunction

    // Multiply by x in GF(2^4) modulo x^4+x+1.
    function automatic logic [3:0] gf2(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [15:0] f_fn(input logic [15:0] x);
        logic [3:0] a0, a1, a2, a3, y0, y1, y2, y3;
        a0 = sbox(x[15:12]);
        a1 = sbox(x[11:8]);
        a2 = sbox(x[7:4]);
        a3 = sbox(x[3:0]);
        y0 = gf2(a0) ^ gf2(a1) ^ a1 ^ a2 ^ a3;
        y1 = a0 ^ gf2(a1) ^ gf2(a2) ^ a2 ^ a3;
        y2 = a0 ^ a1 ^ gf2(a2) ^ gf2(a3) ^ a3;
        y3 = gf2(a0) ^ a0 ^ a1 ^ a2 ^ gf2(a3);
        return {sbox(y0), sbox(y1), sbox(y2), sbox(y3)};
    endfunction

    // One application of the schedule's word permutation (k2,k1,k6,k7,k0,k3,k4,k5).
    function automatic logic [2:0] perm_step(input logic [2:0] m);
        case (m)
            3'd0: return 3'd2;  3'd1: return 3'd1;  3'd2: return 3'd6;  3'd3: return 3'd7;
            3'd4: return 3'd0;  3'd5: return 3'd3;  3'd6: return 3'd4;  default: return 3'd5;
        endcase
    endfunction

    // Key word feeding rk_j: position (j+2) mod 8 after floor((j+2)/8) permutations.
    function automatic logic [15:0] key_word(input logic [0:127] k, input logic [5:0] j);
        logic [5:0] jj;
        logic [2:0] idx;
        logic [2:0] n;
        jj  = j + 6'd2;
        idx = jj[2:0];
        n   = jj[5:3];
        for (int t = 0; t < 7; t++) begin
            if (3'(t) < n) idx = perm_step(idx);
        end
        return k[{idx, 4'b0000} +: 16];
    endfunction

    function automatic logic [31:0] con_pair(input logic [4:0] c);
        return {c, 5'd0, c, 2'b00, c, 5'd0, c} ^ 32'h6547a98b;
    endfunction

    logic [15:0] w0, w1, w2, w3, x1n, x3n;
    logic [15:0] rk_a, rk_b, rk0, rk1, wk0_in, wk1_in, wk2, wk3;
    logic [5:0]  ja, jb;
    logic [31:0] con;
    logic [0:63] round_out, final_out;

    always_comb begin
        w0 = state_q[0:15];
        w1 = state_q[16:31];
        w2 = state_q[32:47];
        w3 = state_q[48:63];
        ja = 6'd60 - {round_q, 1'b0};
        jb = ja + 6'd1;
        con  = con_pair(5'd31 - round_q);
        rk_a = key_word(key_q, ja) ^ con[31:16];
        rk_b = key_word(key_q, jb) ^ con[15:0];
        rk0  = round_q[0] ? rk_b : rk_a;
        rk1  = round_q[0] ? rk_a : rk_b;
        x1n  = w1 ^ f_fn(w0) ^ rk0;
        x3n  = w3 ^ f_fn(w2) ^ rk1;
        round_out = {x1n[15:8], x3n[7:0], w2[15:8], w0[7:0],
                     x3n[15:8], x1n[7:0], w0[15:8], w2[7:0]};
        wk0_in = {keyin[64:71], keyin[120:127]};
        wk1_in = {keyin[112:119], keyin[72:79]};
        wk2    = {key_q[0:7], key_q[24:31]};
        wk3    = {key_q[16:23], key_q[8:15]};
        // Last round skips the permutation.
        final_out = {w0 ^ wk2, x1n, w2 ^ wk3, x3n};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q     <= StIdle;
            round_q   <= '0;
            key_q     <= '0;
            state_q   <= '0;
            plaintext <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (fsm_q)
                StIdle: begin
                    if (start) begin
                        key_q   <= keyin;
                        state_q <= {ciphertext[0:15] ^ wk0_in, ciphertext[16:31],
                                    ciphertext[32:47] ^ wk1_in, ciphertext[48:63]};
                        round_q <= '0;
                        busy    <= 1'b1;
                        fsm_q   <= StRun;
                    end
                end
                StRun: begin
                    if (round_q == 5'd30) begin
                        plaintext <= final_out;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        round_q   <= '0;
                        fsm_q     <= StDone;
                    end else begin
                        state_q <= round_out;
                        round_q <= round_q + 5'd1;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    fsm_q <= StIdle;
                end
                default: fsm_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_piccolo128_dec_iter.sv
// Bench for piccolo128_dec_iter: ciphertexts come from a behavioural Piccolo-128
// encryption model; the DUT must return the original block with exact timing.
`timescale 1ns/1ps
module tb_piccolo128_dec_iter;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [0:127] keyin;
    logic [0:63]  ciphertext;
    logic [0:63]  plaintext;
    logic         busy;
    logic         done;

    piccolo128_dec_iter dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .keyin      (keyin),
        .ciphertext (ciphertext),
        .plaintext  (plaintext),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural encryption model ----------------
    localparam logic [3:0] SBOX [16] = '{4'he, 4'h4, 4'hb, 4'h2, 4'h3, 4'h8, 4'h0, 4'h9,
                                         4'h1, 4'ha, 4'h7, 4'hf, 4'h6, 4'hc, 4'h5, 4'hd};
    localparam logic [3:0] MIX [4][4] = '{'{4'h2, 4'h3, 4'h1, 4'h1}, '{4'h1, 4'h2, 4'h3, 4'h1},
                                          '{4'h1, 4'h1, 4'h2, 4'h3}, '{4'h3, 4'h1, 4'h1, 4'h2}};
    localparam int RPQ [8] = '{2, 7, 4, 1, 6, 3, 0, 5};

    logic [15:0] rk_m [62];
    logic [15:0] wk_m [4];

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r, aa;
        r  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r ^= aa;
            aa = aa[3] ? ((aa << 1) ^ 4'h3) : (aa << 1);
        end
        return r;
    endfunction

    function automatic logic [15:0] f_m(input logic [15:0] x);
        logic [3:0]  a [4];
        logic [3:0]  y [4];
        logic [15:0] r;
        for (int k = 0; k < 4; k++) a[k] = SBOX[x[15-4*k -: 4]];
        for (int row = 0; row < 4; row++) begin
            y[row] = 4'h0;
            for (int c = 0; c < 4; c++) y[row] ^= gmul(MIX[row][c], a[c]);
        end
        for (int k = 0; k < 4; k++) r[15-4*k -: 4] = SBOX[y[k]];
        return r;
    endfunction

    function automatic logic [63:0] rp_m(input logic [63:0] s);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[63-8*k -: 8] = s[63-8*RPQ[k] -: 8];
        return r;
    endfunction

    task automatic model_keys(input logic [127:0] key);
        logic [15:0] k [8];
        logic [15:0] t [8];
        logic [4:0]  c;
        logic [31:0] pair;
        for (int m = 0; m < 8; m++) k[m] = key[127-16*m -: 16];
        wk_m[0] = {k[0][15:8], k[1][7:0]};
        wk_m[1] = {k[1][15:8], k[0][7:0]};
        wk_m[2] = {k[4][15:8], k[7][7:0]};
        wk_m[3] = {k[7][15:8], k[4][7:0]};
        for (int j = 0; j < 62; j++) begin
            if ((j + 2) % 8 == 0) begin
                t = k;
                k[0] = t[2]; k[1] = t[1]; k[2] = t[6]; k[3] = t[7];
                k[4] = t[0]; k[5] = t[3]; k[6] = t[4]; k[7] = t[5];
            end
            c    = 5'(j / 2 + 1);
            pair = {c, 5'd0, c, 2'b00, c, 5'd0, c} ^ 32'h6547a98b;
            rk_m[j] = k[(j + 2) % 8] ^ ((j % 2 == 0) ? pair[31:16] : pair[15:0]);
        end
    endtask

    function automatic logic [63:0] enc_m(input logic [63:0] pt);
        logic [63:0] s;
        logic [15:0] x0, x1, x2, x3;
        s = pt;
        s[63:48] ^= wk_m[0];
        s[31:16] ^= wk_m[1];
        for (int i = 0; i < 31; i++) begin
            {x0, x1, x2, x3} = s;
            x1 ^= f_m(x0) ^ rk_m[2*i];
            x3 ^= f_m(x2) ^ rk_m[2*i+1];
            s = {x0, x1, x2, x3};
            if (i < 30) s = rp_m(s);
        end
        s[63:48] ^= wk_m[2];
        s[31:16] ^= wk_m[3];
        return s;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_dec(input string name, input logic [127:0] key, input logic [63:0] ct,
                           input logic [63:0] exp, input bit scramble);
        logic [63:0] prev;
        int  n;
        bit  seen;
        prev       = plaintext;
        start      = 1'b1;
        keyin      = key;
        ciphertext = ct;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check({name, " latency"}, 64'(n), 64'd31);
                check({name, " plaintext"}, plaintext, exp);
                start = 1'b1;  // lands in the DONE cycle and must be ignored
            end else begin
                if (n == 0) begin
                    check({name, " busy after start"}, 64'(busy), 64'd1);
                    check({name, " plaintext held at start"}, plaintext, prev);
                end
                if (n == 15) check({name, " busy/done mid-run"}, 64'({busy, done}), 64'd2);
                if (scramble) begin
                    start      = 1'($urandom_range(0, 1));
                    keyin      = {$urandom(), $urandom(), $urandom(), $urandom()};
                    ciphertext = {$urandom(), $urandom()};
                end else begin
                    start = 1'b0;
                end
                n++;
            end
        end
        if (!seen) check({name, " done timeout"}, 64'(n), 64'd31);
        @(negedge clk);
        start = 1'b0;
        check({name, " idle after done"}, 64'({busy, done}), 64'd0);
        check({name, " plaintext held"}, plaintext, exp);
    endtask

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [63:0]  pt;
        bit           scramble;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [63:0]  ct;
        logic [127:0] key;
        logic [63:0]  pt;
        int pulses, last, extra, aborted_done, n;

        vecs[0] = '{"ref vector", 128'h00112233445566778899aabbccddeeff, 64'h0123456789abcdef, 1'b0};
        vecs[1] = '{"zero key/block", 128'h0, 64'h0, 1'b0};
        vecs[2] = '{"ones key/block", {128{1'b1}}, {64{1'b1}}, 1'b0};
        vecs[3] = '{"ones key zero block", {128{1'b1}}, 64'h0, 1'b1};
        vecs[4] = '{"pattern", 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_1234_fedc, 64'hdeadbeef0badf00d,
                    1'b1};

        reset      = 1'b0;
        start      = 1'b0;
        keyin      = '0;
        ciphertext = '0;
        #1;
        check("reset plaintext", plaintext, 64'h0);
        check("reset busy/done", 64'({busy, done}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            model_keys(vecs[v].key);
            ct = enc_m(vecs[v].pt);
            run_dec(vecs[v].name, vecs[v].key, ct, vecs[v].pt, vecs[v].scramble);
        end

        // Reset at round 15 of a run, then a clean rerun.
        model_keys(vecs[0].key);
        ct         = enc_m(vecs[0].pt);
        start      = 1'b1;
        keyin      = vecs[0].key;
        ciphertext = ct;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort busy/done", 64'({busy, done}), 64'd0);
        check("abort plaintext", plaintext, 64'h0);
        @(negedge clk);
        reset        = 1'b1;
        aborted_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) aborted_done++;
        end
        check("no activity after abort", 64'(aborted_done), 64'd0);
        run_dec("after abort", vecs[0].key, ct, vecs[0].pt, 1'b0);

        // Start held for 100 cycles: 31 run cycles, DONE, then one IDLE cycle
        // before the next acceptance, so completions are 33 cycles apart.
        model_keys(vecs[4].key);
        ct         = enc_m(vecs[4].pt);
        start      = 1'b1;
        keyin      = vecs[4].key;
        ciphertext = ct;
        pulses     = 0;
        last       = -1;
        for (int c = 0; c < 99; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check("held start plaintext", plaintext, vecs[4].pt);
                if (last >= 0) check("held start spacing", 64'(c - last), 64'd33);
                last = c;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("held start pulses", 64'(pulses), 64'd3);
        extra = 0;
        n     = 0;
        while (n < 60 && (busy || done || extra == 0)) begin
            @(negedge clk);
            if (done) begin
                extra++;
                check("held start trailing plaintext", plaintext, vecs[4].pt);
            end
            n++;
        end
        check("held start trailing run", 64'(extra), 64'd1);

        // Random pairs with inputs scrambled every cycle after acceptance.
        for (int r = 0; r < 1000; r++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom()};
            model_keys(key);
            ct = enc_m(pt);
            run_dec("random", key, ct, pt, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
